// File: rtl/usb_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_decoder_if
// Description : Bundle for the USB receive line decoder. Carries the raw
//               D+/D- line inputs toward the decoder and the decoded bit
//               strobes / packet status back to the packet logic.
//               master : line driver + packet logic side
//                        (drives d_plus_in/d_minus_in, observes rx_*)
//               slave  : the decoder itself
// Revision    : 1.0  initial release
// ============================================================================
interface usb_rx_decoder_if;
    logic d_plus_in;     // raw D+ line (asynchronous)
    logic d_minus_in;    // raw D- line (asynchronous)
    logic rx_bit;        // decoded data bit, valid with rx_bit_valid
    logic rx_bit_valid;  // one-cycle strobe per non-stuffed bit
    logic rx_active;     // packet in progress
    logic rx_eop;        // one-cycle strobe on valid end of packet
    logic rx_error;      // sticky error, cleared at next packet start

    modport master (
        output d_plus_in,
        output d_minus_in,
        input  rx_bit,
        input  rx_bit_valid,
        input  rx_active,
        input  rx_eop,
        input  rx_error
    );

    modport slave (
        input  d_plus_in,
        input  d_minus_in,
        output rx_bit,
        output rx_bit_valid,
        output rx_active,
        output rx_eop,
        output rx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_decoder
// Description : Receive-side USB line decoder. Synchronizes D+/D-, recovers
//               bit timing from line edges, NRZI-decodes, strips stuffed
//               bits and detects EOP.
// Ports       : clk    - system clock
//               n_rst  - asynchronous active-low reset
//               bus    - usb_rx_decoder_if.slave (line inputs, rx_* outputs)
// Parameters  : CLKS_PER_BIT (even, >= 4), STUFF_LEN, EOP_MAX_BITS
// Options     : RX_STUFF_CHECK_EN - when defined, a 1 at a stuffed-bit
//               position is a receive error; otherwise it is dropped.
// Revision    : 1.0  initial release
// ============================================================================
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_MAX_BITS = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_rx_decoder_if.slave  bus
);

    localparam int c_TW     = $clog2(CLKS_PER_BIT);
    localparam int c_ONES_W = $clog2(STUFF_LEN + 1);
    localparam int c_SE0_W  = $clog2(EOP_MAX_BITS + 1);

    localparam logic [c_TW-1:0]     c_SAMPLE  = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0]     c_TMAX    = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_ONES_W-1:0] c_STUFF   = c_ONES_W'(STUFF_LEN);
    localparam logic [c_SE0_W-1:0]  c_SE0_MAX = c_SE0_W'(EOP_MAX_BITS);

    // Line states as {D+, D-}
    localparam logic [1:0] c_J   = 2'b10;
    localparam logic [1:0] c_K   = 2'b01;
    localparam logic [1:0] c_SE0 = 2'b00;
    localparam logic [1:0] c_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_EOP_SE0 = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          sync1_q,     sync1_d;
    logic [1:0]          sync2_q,     sync2_d;
    logic [1:0]          line_last_q, line_last_d;
    logic [1:0]          prev_line_q, prev_line_d;
    logic [c_TW-1:0]     timer_q,     timer_d;
    logic [c_ONES_W-1:0] ones_q,      ones_d;
    logic [c_SE0_W-1:0]  se0_cnt_q,   se0_cnt_d;
    logic [2:0]          j_cnt_q,     j_cnt_d;
    logic                rx_bit_q,       rx_bit_d;
    logic                rx_bit_valid_q, rx_bit_valid_d;
    logic                rx_active_q,    rx_active_d;
    logic                rx_eop_q,       rx_eop_d;
    logic                rx_error_q,     rx_error_d;

    logic w_change;
    logic w_sample;
    logic w_bit;
    logic w_to_error;

    always_comb begin
        sync1_d     = {bus.d_plus_in, bus.d_minus_in};
        sync2_d     = sync1_q;
        line_last_d = sync2_q;

        // Any change of the synced pair re-centres the bit timer; that
        // cycle never samples, so the resync always wins.
        w_change = (sync2_q != line_last_q);
        w_sample = (state_q != ST_IDLE) && !w_change && (timer_q == c_SAMPLE);
        // NRZI: an unchanged level decodes as 1
        w_bit    = (sync2_q == prev_line_q);

        state_d        = state_q;
        prev_line_d    = prev_line_q;
        ones_d         = ones_q;
        se0_cnt_d      = se0_cnt_q;
        j_cnt_d        = j_cnt_q;
        rx_bit_d       = rx_bit_q;
        rx_bit_valid_d = 1'b0;
        rx_active_d    = rx_active_q;
        rx_eop_d       = 1'b0;
        rx_error_d     = rx_error_q;
        w_to_error     = 1'b0;

        if (state_q == ST_IDLE || w_change) begin
            timer_d = '0;
        end else if (timer_q == c_TMAX) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + c_TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (sync2_q == c_K && line_last_q == c_J) begin
                    state_d     = ST_RECEIVE;
                    ones_d      = '0;
                    rx_error_d  = 1'b0;
                    rx_active_d = 1'b1;
                    prev_line_d = c_J;
                end
            end

            ST_RECEIVE: begin
                if (w_sample) begin
                    case (sync2_q)
                        c_J, c_K: begin
                            prev_line_d = sync2_q;
                            if (ones_q == c_STUFF) begin
                                // Stuffed-bit slot: never delivered
                                ones_d = '0;
`ifdef RX_STUFF_CHECK_EN
                                if (w_bit) begin
                                    w_to_error = 1'b1;
                                end
`endif
                            end else begin
                                rx_bit_d       = w_bit;
                                rx_bit_valid_d = 1'b1;
                                ones_d         = w_bit ? ones_q + c_ONES_W'(1) : '0;
                            end
                        end
                        c_SE0: begin
                            se0_cnt_d = c_SE0_W'(1);
                            state_d   = ST_EOP_SE0;
                        end
                        default: w_to_error = 1'b1;
                    endcase
                end
            end

            ST_EOP_SE0: begin
                if (w_sample) begin
                    if (sync2_q == c_SE0) begin
                        // Incrementing past the limit means SE0 lasted too long
                        if (se0_cnt_q == c_SE0_MAX) begin
                            w_to_error = 1'b1;
                        end else begin
                            se0_cnt_d = se0_cnt_q + c_SE0_W'(1);
                        end
                    end else if (sync2_q == c_J && se0_cnt_q >= c_SE0_W'(2)) begin
                        rx_eop_d    = 1'b1;
                        rx_active_d = 1'b0;
                        prev_line_d = c_J;
                        state_d     = ST_IDLE;
                    end else begin
                        w_to_error = 1'b1;
                    end
                end
            end

            default: begin  // ST_ERROR: wait for 8 consecutive J samples
                if (w_sample) begin
                    if (sync2_q == c_J) begin
                        if (j_cnt_q == 3'd7) begin
                            rx_active_d = 1'b0;
                            prev_line_d = c_J;
                            state_d     = ST_IDLE;
                        end else begin
                            j_cnt_d = j_cnt_q + 3'd1;
                        end
                    end else begin
                        j_cnt_d = 3'd0;
                    end
                end
            end
        endcase

        if (w_to_error) begin
            state_d    = ST_ERROR;
            rx_error_d = 1'b1;
            j_cnt_d    = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= ST_IDLE;
            sync1_q        <= c_J;
            sync2_q        <= c_J;
            line_last_q    <= c_J;
            prev_line_q    <= c_J;
            timer_q        <= '0;
            ones_q         <= '0;
            se0_cnt_q      <= '0;
            j_cnt_q        <= 3'd0;
            rx_bit_q       <= 1'b0;
            rx_bit_valid_q <= 1'b0;
            rx_active_q    <= 1'b0;
            rx_eop_q       <= 1'b0;
            rx_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            line_last_q    <= line_last_d;
            prev_line_q    <= prev_line_d;
            timer_q        <= timer_d;
            ones_q         <= ones_d;
            se0_cnt_q      <= se0_cnt_d;
            j_cnt_q        <= j_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            rx_active_q    <= rx_active_d;
            rx_eop_q       <= rx_eop_d;
            rx_error_q     <= rx_error_d;
        end
    end

    assign bus.rx_bit       = rx_bit_q;
    assign bus.rx_bit_valid = rx_bit_valid_q;
    assign bus.rx_active    = rx_active_q;
    assign bus.rx_eop       = rx_eop_q;
    assign bus.rx_error     = rx_error_q;

endmodule
`default_nettype wire
